// File: rtl/score_keeper_if.sv
// Handshake bundle between game_controller, score_keeper and the LED/SSD top level.
// The master drives start and the point pulses; score_keeper (slave) drives everything else.
interface score_keeper_if;
  logic       start;
  logic       p1_point;
  logic       p2_point;
  logic [1:0] state;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;
  logic       game_over;
  logic [3:0] ssd3;
  logic [3:0] ssd2;
  logic [3:0] ssd1;
  logic [3:0] ssd0;

  modport master (
    output start, p1_point, p2_point,
    input  state, p1_score, p2_score, winner, game_over, ssd3, ssd2, ssd1, ssd0
  );

  modport slave (
    input  start, p1_point, p2_point,
    output state, p1_score, p2_score, winner, game_over, ssd3, ssd2, ssd1, ssd0
  );
endinterface

// File: rtl/score_keeper.sv
// Pong match scorer: game state, scores, serve owner, winner and SSD digit nibbles, all registered.
// SCORE_LOCKOUT_EN adds a post-point window that ignores further point pulses for LOCKOUT_CYCLES cycles.
module score_keeper #(
  parameter int unsigned WIN_SCORE = 10
`ifdef SCORE_LOCKOUT_EN
  , parameter int unsigned LOCKOUT_CYCLES = 32
`endif
) (
  input  logic          clk,
  input  logic          reset,
  score_keeper_if.slave bus
);

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } state_t;

  localparam logic [3:0] WIN = WIN_SCORE[3:0];

  state_t     r_state;
  logic [3:0] r_p1_score;
  logic [3:0] r_p2_score;
  logic [1:0] r_winner;
  logic       r_game_over;
  logic       r_start_q;

  state_t     w_state_nxt;
  logic [3:0] w_p1_nxt;
  logic [3:0] w_p2_nxt;
  logic [1:0] w_winner_nxt;
  logic       w_game_over_nxt;
  logic       w_start_rise;
  logic       w_p1_acc;
  logic       w_p2_acc;
  logic [3:0] w_p1_inc;
  logic [3:0] w_p2_inc;

  // start_q resets high so a switch already up at reset cannot launch a match.
  assign w_start_rise = bus.start & ~r_start_q;
  assign w_p1_inc     = r_p1_score + 4'd1;
  assign w_p2_inc     = r_p2_score + 4'd1;

`ifdef SCORE_LOCKOUT_EN
  logic [7:0] r_lock;
  logic [7:0] w_lock_nxt;
  logic       w_scored;

  assign w_p1_acc = bus.p1_point & (r_lock == 8'd0);
  assign w_p2_acc = bus.p2_point & (r_lock == 8'd0);
  assign w_scored = ((r_state == QGAME_1) || (r_state == QGAME_2)) & bus.start & (w_p1_acc ^ w_p2_acc);

  always_comb begin
    w_lock_nxt = (r_lock != 8'd0) ? (r_lock - 8'd1) : 8'd0;
    if (w_state_nxt == QI) begin
      w_lock_nxt = 8'd0;
    end else if (w_scored) begin
      w_lock_nxt = LOCKOUT_CYCLES[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock <= 8'd0;
    end else begin
      r_lock <= w_lock_nxt;
    end
  end
`else
  assign w_p1_acc = bus.p1_point;
  assign w_p2_acc = bus.p2_point;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_p1_nxt        = r_p1_score;
    w_p2_nxt        = r_p2_score;
    w_winner_nxt    = r_winner;
    w_game_over_nxt = 1'b0;
    case (r_state)
      QI: begin
        w_p1_nxt     = 4'd0;
        w_p2_nxt     = 4'd0;
        w_winner_nxt = 2'b00;
        if (w_start_rise) begin
          w_state_nxt = QGAME_1;
        end
      end
      QGAME_1, QGAME_2: begin
        // Abort wins over any point pulse; simultaneous pulses are a let.
        if (!bus.start) begin
          w_state_nxt = QI;
          w_p1_nxt    = 4'd0;
          w_p2_nxt    = 4'd0;
        end else if (w_p1_acc && !w_p2_acc) begin
          w_p1_nxt = w_p1_inc;
          if (w_p1_inc == WIN) begin
            w_state_nxt     = QDONE;
            w_winner_nxt    = 2'b01;
            w_game_over_nxt = 1'b1;
          end else begin
            w_state_nxt = QGAME_2;
          end
        end else if (w_p2_acc && !w_p1_acc) begin
          w_p2_nxt = w_p2_inc;
          if (w_p2_inc == WIN) begin
            w_state_nxt     = QDONE;
            w_winner_nxt    = 2'b10;
            w_game_over_nxt = 1'b1;
          end else begin
            w_state_nxt = QGAME_1;
          end
        end
      end
      QDONE: begin
        if (!bus.start) begin
          w_state_nxt  = QI;
          w_p1_nxt     = 4'd0;
          w_p2_nxt     = 4'd0;
          w_winner_nxt = 2'b00;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= QI;
      r_p1_score  <= 4'd0;
      r_p2_score  <= 4'd0;
      r_winner    <= 2'b00;
      r_game_over <= 1'b0;
      r_start_q   <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_p1_score  <= w_p1_nxt;
      r_p2_score  <= w_p2_nxt;
      r_winner    <= w_winner_nxt;
      r_game_over <= w_game_over_nxt;
      r_start_q   <= bus.start;
    end
  end

  assign bus.state     = r_state;
  assign bus.p1_score  = r_p1_score;
  assign bus.p2_score  = r_p2_score;
  assign bus.winner    = r_winner;
  assign bus.game_over = r_game_over;
  assign bus.ssd3      = r_p1_score;
  assign bus.ssd2      = 4'hF;
  assign bus.ssd1      = 4'hF;
  assign bus.ssd0      = r_p2_score;

endmodule
